// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the fetch/data RAM port arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    localparam int WAIT_W = 4;

    function automatic logic [31:0] zext(input logic [1:0] size, input logic [31:0] d);
        return size == SZ_BYTE ? {24'd0, d[7:0]} : size == SZ_HALF ? {16'd0, d[15:0]} : d;
    endfunction

endpackage

// File: rtl/ram_wait_counter.sv
// ram_wait_counter: counts RAM wait cycles and flags when WAIT_CYCLES is reached
module ram_wait_counter
    import ram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_CYCLES[WAIT_W-1:0];

    logic [WAIT_W-1:0] count;

    // cycle counter, held at zero while cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count <= '0;
        else if (clear) count <= '0;
        else if (enable) count <= count + 1'b1;
    end

    assign done = count == LIMIT;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one data RAM between fetch and load/store via MFA/MOC handshakes; ARB_ROUND_ROBIN_EN selects round-robin tie breaking instead of fixed data priority
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_mfa,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_moc,
    input  logic              d_mfa,
    input  logic              d_rw,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_moc,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [1:0]        ram_size,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t state;
    logic grant;
    logic pick;
    logic cnt_done;
    logic [1:0] d_size_n;
    logic [ADDR_W-1:0] d_addr_al;
    logic [ADDR_W-1:0] if_addr_al;

    assign d_size_n   = d_size == 2'b11 ? SZ_WORD : d_size;
    assign d_addr_al  = d_size_n == SZ_BYTE ? d_addr :
                        d_size_n == SZ_HALF ? {d_addr[ADDR_W-1:1], 1'b0} : {d_addr[ADDR_W-1:2], 2'b00};
    assign if_addr_al = {if_addr[ADDR_W-1:2], 2'b00};

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
    assign pick = (if_mfa && d_mfa) ? ~last_grant : d_mfa;
`else
    assign pick = d_mfa ? REQ_DATA : REQ_FETCH;
`endif

    ram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE),
        .enable(state == ACCESS),
        .done  (cnt_done)
    );

    // arbitration FSM with registered RAM drive, read capture and MOC returns
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= REQ_FETCH;
            ram_en    <= 1'b0;
            ram_rw    <= 1'b0;
            ram_size  <= 2'b00;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_moc    <= 1'b0;
            d_moc     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= REQ_DATA;
`endif
        end else begin
            case (state)
                IDLE: if (if_mfa || d_mfa) begin
                    grant     <= pick;
                    ram_en    <= 1'b1;
                    ram_rw    <= pick ? d_rw : 1'b1;
                    ram_size  <= pick ? d_size_n : SZ_WORD;
                    ram_addr  <= pick ? d_addr_al : if_addr_al;
                    ram_wdata <= pick ? d_wdata : 32'd0;
                    state     <= ACCESS;
                end
                ACCESS: if (cnt_done) begin
                    ram_en <= 1'b0;
                    if (ram_rw && grant) d_rdata <= zext(ram_size, ram_rdata);
                    if (ram_rw && !grant) if_rdata <= ram_rdata;
                    d_moc  <= grant;
                    if_moc <= !grant;
                    state  <= DONE;
                end
                DONE: if (!(grant ? d_mfa : if_mfa)) begin
                    d_moc  <= 1'b0;
                    if_moc <= 1'b0;
                    state  <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant <= grant;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single data RAM between the instruction-fetch path and the load/store datapath of the ARM simulator core. Each requester runs the existing MFA/MOC four-phase handshake used by the control unit's wait states. The arbiter grants one requester at a time, drives the RAM for a fixed number of wait cycles, captures read data, and returns MOC to the granted side only. It sits between the control unit / datapath and the RAM model.

## Interface
- ADDR_W, 8, RAM byte-address width
- WAIT_CYCLES, 2, extra RAM cycles per access beyond the first (0..15)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- if_mfa  in  1  fetch request; held until if_moc seen
- if_addr  in  ADDR_W  fetch address; always a word access, always a read
- if_rdata  out  32  fetched word; reset 0
- if_moc  out  1  fetch complete; reset 0
- d_mfa  in  1  data request; held until d_moc seen
- d_rw  in  1  1 = read, 0 = write
- d_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word
- d_addr  in  ADDR_W  data address
- d_wdata  in  32  store data, right-justified
- d_rdata  out  32  load data, right-justified, zero-extended; reset 0
- d_moc  out  1  data complete; reset 0
- ram_en  out  1  RAM enable; reset 0
- ram_rw, ram_size, ram_addr, ram_wdata  out  1/2/ADDR_W/32  registered copies of the granted request; reset 0
- ram_rdata  in  32  RAM read data, valid while ram_en is high

## Operation
- States: IDLE, ACCESS, DONE. Reset state IDLE.
- IDLE: both MFAs are sampled at each rising edge. If none is high, stay in IDLE. If one is high, grant it. If both are high, apply the arbitration policy (see Configuration). On grant, latch requester id, rw, size, addr and wdata into the ram_* registers. Fetch forces rw=1 and size=10. Load wait counter = 0. Go to ACCESS.
- ACCESS: ram_en = 1 and ram_* stable. Counter increments each edge. On the edge where counter == WAIT_CYCLES:
  - for a read, capture ram_rdata into if_rdata or d_rdata of the granted side;
  - go to DONE.
- Address alignment: ram_addr low bits are forced to 0 for halfword (bit 0) and word (bits 1:0). No fault is raised.
- DONE: ram_en = 0. The granted side's moc = 1. When that side's mfa is low at an edge, moc drops, last_grant is updated, and the FSM returns to IDLE.
- MFA dropped before completion: the access still runs to completion and is never aborted. In DONE, mfa is already low, so moc is high for exactly one cycle.
- The non-granted requester's moc stays 0 throughout. Its rdata register holds its previous value.
- Writes leave both rdata registers unchanged.

## Timing
- Request sampled at edge k. ram_en is high after edge k through edge k+WAIT_CYCLES+1, i.e. WAIT_CYCLES+1 cycles.
- Read data is captured at edge k+WAIT_CYCLES+1, and moc is high after that same edge.
- Requester lowers mfa, which is sampled at edge m. moc is low after edge m, and the FSM is in IDLE after edge m. The earliest next grant is at edge m+1.
- Back-to-back grant to the other requester: at least one IDLE cycle between accesses.
- Reset asserted at any time:
  - immediately IDLE; ram_en, both moc, all ram_* and both rdata = 0;
  - last_grant = DATA, so fetch wins the first tie;
  - any in-flight access is lost.
- All outputs are registered. There are no combinational paths from mfa to moc or ram_en.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a tie, grant the requester other than last_grant. Neither requester waits more than one access.
- Undefined: fixed priority, data over fetch, on every tie. last_grant is not implemented.
- Single-requester behaviour is identical in both builds.

## Structure
- Package ram_arb_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - requester id constants REQ_FETCH, REQ_DATA;
  - WAIT_W = 4.
- One sub-module, ram_wait_counter: clear, enable, compare-to-WAIT_CYCLES, with a done flag.
- Alignment masking and read-data zero-extension stay inline in the arbiter.

## Test plan
- Fetch only, WAIT_CYCLES=2, if_addr=0x10, RAM returns 0xE0846004 → ram_en high 3 cycles, if_rdata=0xE0846004, if_moc high 3 edges after grant, d_moc stays 0.
- Data byte store, d_addr=0x23, d_wdata=0x000000AB → ram_size=00, ram_addr=0x23, ram_rw=0, d_rdata unchanged, d_moc asserted.
- Simultaneous mfa from idle after reset → fetch granted first. With ARB_ROUND_ROBIN_EN, a repeated tie then grants data. Without it, data is granted on every tie.
- Word load at d_addr=0x47 → ram_addr=0x44. Halfword load at 0x45, RAM returns 0x1234ABCD → ram_addr=0x44, d_rdata=0x0000ABCD.
- d_mfa dropped mid-ACCESS → access completes, d_moc is a single-cycle pulse, FSM returns to IDLE.
- Reset asserted during ACCESS → all outputs 0 immediately. After release, a pending if_mfa is granted on the first edge.
